// File: rtl/branch_cond_unit.sv
// Branch condition unit: captures a bus operand and condition code on request, evaluates one of
// eight sign/zero conditions and returns a registered taken flag under a valid/ack handshake.
module branch_cond_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              con_in,
    input  logic [2:0]        cond_code,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              con_ack,
    output logic              con_out,
    output logic              con_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  eval_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StHold
    } state_e;

    typedef enum logic [2:0] {
        CcZero    = 3'b000,
        CcNonZero = 3'b001,
        CcGeZero  = 3'b010,
        CcNeg     = 3'b011,
        CcAlways  = 3'b100,
        CcNever   = 3'b101,
        CcPos     = 3'b110,
        CcLeZero  = 3'b111
    } cond_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   op_q, op_d;
    cond_e               code_q, code_d;
    logic                con_out_q, con_out_d;
    logic                con_valid_q, con_valid_d;
    logic [CNT_W-1:0]    eval_cnt_q, eval_cnt_d;
    logic [CNT_W-1:0]    taken_cnt_q, taken_cnt_d;

    logic                capture;
    logic                flag;
    logic                op_zero;
    logic                op_sign;

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a new request in HOLD takes priority over the ack
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (con_in) state_d = StEval;
            StEval: state_d = StHold;
            StHold: begin
                if (con_in) begin
                    state_d = StEval;
                end else if (con_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy    = (state_q == StEval);
        capture = con_in && (state_q != StEval);
    end

    // Condition evaluation looks only at the captured operand and code
    always_comb begin
        op_zero = ~|op_q;
        op_sign = op_q[DATA_W-1];
        flag    = 1'b0;
        unique case (code_q)
            CcZero:    flag = op_zero;
            CcNonZero: flag = ~op_zero;
            CcGeZero:  flag = ~op_sign;
            CcNeg:     flag = op_sign;
            CcAlways:  flag = 1'b1;
            CcNever:   flag = 1'b0;
            CcPos:     flag = ~op_sign & ~op_zero;
            CcLeZero:  flag = op_sign | op_zero;
            default:   flag = 1'b0;
        endcase
    end

    // Datapath next-state: capture, result update and saturating counters
    always_comb begin
        op_d        = op_q;
        code_d      = code_q;
        con_out_d   = con_out_q;
        con_valid_d = con_valid_q;
        eval_cnt_d  = eval_cnt_q;
        taken_cnt_d = taken_cnt_q;

        if (capture) begin
            op_d        = bus_in;
            code_d      = cond_e'(cond_code);
            con_valid_d = 1'b0;
        end else if (state_q == StHold && con_ack) begin
            con_valid_d = 1'b0;
        end

        if (state_q == StEval) begin
            con_out_d   = flag;
            con_valid_d = 1'b1;
            if (eval_cnt_q != {CNT_W{1'b1}}) begin
                eval_cnt_d = eval_cnt_q + CNT_W'(1);
            end
            if (flag && (taken_cnt_q != {CNT_W{1'b1}})) begin
                taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            op_q        <= '0;
            code_q      <= CcZero;
            con_out_q   <= 1'b0;
            con_valid_q <= 1'b0;
            eval_cnt_q  <= '0;
            taken_cnt_q <= '0;
        end else begin
            op_q        <= op_d;
            code_q      <= code_d;
            con_out_q   <= con_out_d;
            con_valid_q <= con_valid_d;
            eval_cnt_q  <= eval_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign con_out   = con_out_q;
    assign con_valid = con_valid_q;
    assign eval_cnt  = eval_cnt_q;
    assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Randomised and directed bench for branch_cond_unit against a transaction-level reference model;
// a second instance with 2-bit counters exercises saturation on the same stimulus.
module tb_branch_cond_unit;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          clr;
    logic          con_in;
    logic [2:0]    cond_code;
    logic [DW-1:0] bus_in;
    logic          con_ack;

    logic          con_out, con_valid, busy;
    logic [15:0]   eval_cnt, taken_cnt;
    logic          s_out, s_valid, s_busy;
    logic [1:0]    s_eval, s_taken;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    bit            m_pending;
    bit            m_valid;
    bit            m_out;
    logic [DW-1:0] m_op;
    logic [2:0]    m_code;
    int            m_eval;
    int            m_taken;

    branch_cond_unit #(.DATA_W(DW), .CNT_W(16)) dut (
        .clk       (clk),
        .clr       (clr),
        .con_in    (con_in),
        .cond_code (cond_code),
        .bus_in    (bus_in),
        .con_ack   (con_ack),
        .con_out   (con_out),
        .con_valid (con_valid),
        .busy      (busy),
        .eval_cnt  (eval_cnt),
        .taken_cnt (taken_cnt)
    );

    branch_cond_unit #(.DATA_W(DW), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .clr       (clr),
        .con_in    (con_in),
        .cond_code (cond_code),
        .bus_in    (bus_in),
        .con_ack   (con_ack),
        .con_out   (s_out),
        .con_valid (s_valid),
        .busy      (s_busy),
        .eval_cnt  (s_eval),
        .taken_cnt (s_taken)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!clr) begin
            assert (!$isunknown(con_in) && !$isunknown(con_ack))
            else $error("con_in/con_ack unknown while out of reset");
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_flag(input logic [2:0] c, input logic [DW-1:0] v);
        int sv;
        sv = $signed(v);
        case (c)
            3'd0:    return sv == 0;
            3'd1:    return sv != 0;
            3'd2:    return sv >= 0;
            3'd3:    return sv < 0;
            3'd4:    return 1'b1;
            3'd5:    return 1'b0;
            3'd6:    return sv > 0;
            default: return sv <= 0;
        endcase
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        m_pending = 0;
        m_valid   = 0;
        m_out     = 0;
        m_op      = '0;
        m_code    = '0;
        m_eval    = 0;
        m_taken   = 0;
    endtask

    // One clock edge of the transaction model: finish an evaluation in flight, else accept a
    // new request, else retire the held result on ack.
    task automatic model_edge();
        bit f;
        if (m_pending) begin
            f         = ref_flag(m_code, m_op);
            m_out     = f;
            m_valid   = 1;
            m_eval    = m_eval + 1;
            m_taken   = m_taken + int'(f);
            m_pending = 0;
        end else if (con_in) begin
            m_op      = bus_in;
            m_code    = cond_code;
            m_pending = 1;
            m_valid   = 0;
        end else if (con_ack) begin
            m_valid = 0;
        end
    endtask

    task automatic check_all();
        check("busy", 32'(busy), 32'(m_pending));
        check("con_valid", 32'(con_valid), 32'(m_valid));
        if (m_valid) check("con_out", 32'(con_out), 32'(m_out));
        check("eval_cnt", 32'(eval_cnt), sat(m_eval, 65535));
        check("taken_cnt", 32'(taken_cnt), sat(m_taken, 65535));
        check("sat_eval_cnt", 32'(s_eval), sat(m_eval, 3));
        check("sat_taken_cnt", 32'(s_taken), sat(m_taken, 3));
    endtask

    task automatic cycle(input bit ci, input bit ack, input logic [2:0] code,
                         input logic [DW-1:0] bus);
        @(negedge clk);
        con_in    = ci;
        con_ack   = ack;
        cond_code = code;
        bus_in    = bus;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        clr = 1'b1;
        #1;
        model_reset();
        check("rst_con_out", 32'(con_out), 32'd0);
        check("rst_con_valid", 32'(con_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_eval_cnt", 32'(eval_cnt), 32'd0);
        check("rst_taken_cnt", 32'(taken_cnt), 32'd0);
        @(negedge clk);
        con_in  = 1'b0;
        con_ack = 1'b0;
        clr     = 1'b0;
    endtask

    // Request, let the operand bus change after capture, then check and ack the result
    task automatic directed(input logic [2:0] code, input logic [DW-1:0] bus, input bit exp);
        cycle(1'b1, 1'b0, code, bus);
        cycle(1'b0, 1'b0, 3'($urandom), $urandom);
        check($sformatf("dir_c%0d_%08h", code, bus), 32'(con_out), 32'(exp));
        check("dir_valid", 32'(con_valid), 32'd1);
        cycle(1'b0, 1'b1, 3'd0, '0);
    endtask

    function automatic logic [DW-1:0] pick_bus();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h0000_0001;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int e0;
        logic [DW-1:0] vals [3];
        logic [2:0]    codes [4];
        bit            exps [4][3];
        vals  = '{32'h8000_0000, 32'h0, 32'h1};
        codes = '{3'b010, 3'b011, 3'b110, 3'b111};
        exps  = '{'{0, 1, 1}, '{1, 0, 0}, '{0, 0, 1}, '{1, 1, 0}};

        clr = 1'b1; con_in = 1'b0; con_ack = 1'b0; cond_code = '0; bus_in = '0;
        model_reset();
        #2;
        check("init_con_out", 32'(con_out), 32'd0);
        check("init_con_valid", 32'(con_valid), 32'd0);
        check("init_eval_cnt", 32'(eval_cnt), 32'd0);
        @(negedge clk);
        clr = 1'b0;

        directed(3'b000, '0, 1'b1);
        directed(3'b001, '0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            for (int v = 0; v < 3; v++) directed(codes[c], vals[v], exps[c][v]);
        end

        // Request while evaluating is ignored
        e0 = int'(eval_cnt);
        cycle(1'b1, 1'b0, 3'b100, 32'h5);
        cycle(1'b1, 1'b0, 3'b101, 32'h5);
        check("eval_ignore_cnt", 32'(eval_cnt), 32'(e0 + 1));
        check("eval_ignore_out", 32'(con_out), 32'd1);

        // Simultaneous request and ack in HOLD re-evaluates
        cycle(1'b1, 1'b1, 3'b101, 32'h5);
        check("reeval_valid_low", 32'(con_valid), 32'd0);
        cycle(1'b0, 1'b0, 3'b100, 32'h5);
        check("reeval_out", 32'(con_out), 32'd0);
        cycle(1'b0, 1'b1, 3'b100, 32'h5);
        check("ack_idle_valid", 32'(con_valid), 32'd0);
        check("ack_idle_retained", 32'(con_out), 32'd0);

        // Saturation of the 2-bit instance
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 3'b100, $urandom);
            cycle(1'b0, 1'b1, 3'b000, '0);
        end
        check("sat_eval_3", 32'(s_eval), 32'd3);
        check("sat_taken_3", 32'(s_taken), 32'd3);
        cycle(1'b1, 1'b0, 3'b101, '0);
        cycle(1'b0, 1'b0, 3'b000, '0);
        check("sat_taken_hold", 32'(s_taken), 32'd3);
        check("wide_taken_5", 32'(taken_cnt), 32'd5);

        // Random traffic with a reset dropped in mid-evaluation
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                cycle(1'b1, 1'b0, 3'b100, '0);
                do_reset();
            end
            cycle(($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 30),
                  3'($urandom), pick_bus());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
